// File: rtl/vpg_mode_ctrl_pkg.sv
// Shared types and helpers for the VPG mode controller: FSM state encoding,
// mode-code validity and counter sizing.
package vpg_mode_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEBOUNCE    = 3'd1,
    ST_ISSUE       = 3'd2,
    ST_WAIT_UNLOCK = 3'd3,
    ST_WAIT_LOCK   = 3'd4,
    ST_SETTLE      = 3'd5
  } vpg_state_e;

  // Codes 4 and 7 have no timing table behind them.
  function automatic logic mode_valid(input logic [2:0] m);
    return (m != 3'd4) && (m != 3'd7);
  endfunction

  // Width that holds 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vpg_sel_debounce.sv
// Mode-select synchroniser plus candidate tracking: a candidate is accepted once
// it has been held unchanged for DEBOUNCE_CYCLES clocks while the FSM is debouncing.
module vpg_sel_debounce
  import vpg_mode_ctrl_pkg::*;
#(
  parameter logic [2:0] INIT_MODE       = 3'd0,
  parameter int         DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode_sel,
  input  logic [2:0] timing_mode,
  input  logic       load,
  input  logic       run,
  output logic       pending,
  output logic       accept,
  output logic [2:0] cand
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    sel_m;
  logic [2:0]    sel_s;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_m <= INIT_MODE;
      sel_s <= INIT_MODE;
    end else begin
      sel_m <= mode_sel;
      sel_s <= sel_m;
    end
  end

  assign pending = mode_valid(sel_s) && (sel_s != timing_mode);

  // Candidate is frozen outside IDLE/DEBOUNCE so ISSUE and retries use it as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand <= INIT_MODE;
      cnt  <= '0;
    end else if (load) begin
      cand <= sel_s;
      cnt  <= '0;
    end else if (run) begin
      if (sel_s != cand) begin
        cand <= sel_s;
        cnt  <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign accept = run && pending && (sel_s == cand) && (cnt == LAST);

endmodule

// File: rtl/vpg_mode_ctrl.sv
// VPG mode controller: debounced mode acceptance, clk_en-aligned change strobe,
// and pixel-PLL relock sequencing that gates vid_reset.
module vpg_mode_ctrl
  import vpg_mode_ctrl_pkg::*;
#(
  parameter logic [2:0] INIT_MODE       = 3'd0,
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         UNLOCK_TIMEOUT  = 4096,
  parameter int         LOCK_TIMEOUT    = 1048576,
  parameter int         SETTLE_CYCLES   = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [2:0] mode_sel,
  input  logic       pll_locked,
  output logic [2:0] timing_mode,
  output logic       timing_mode_change,
  output logic       vid_reset,
  output logic       busy,
  output logic       lock_err
);

  localparam int            CW          = cnt_width(imax(UNLOCK_TIMEOUT, imax(LOCK_TIMEOUT, SETTLE_CYCLES)));
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  vpg_state_e    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    mode_q, mode_n;
  logic          chg_q, chg_n;
  logic          err_q, err_n;
  logic          lock_m, lock_s;
  logic          pending, accept;
  logic [2:0]    cand;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  vpg_sel_debounce #(
    .INIT_MODE       (INIT_MODE),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sel_debounce (
    .clk         (clk),
    .reset       (reset),
    .mode_sel    (mode_sel),
    .timing_mode (mode_q),
    .load        (state_q == ST_IDLE),
    .run         (state_q == ST_DEBOUNCE),
    .pending     (pending),
    .accept      (accept),
    .cand        (cand)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      mode_q  <= INIT_MODE;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      mode_q  <= mode_n;
      chg_q   <= chg_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    mode_n  = mode_q;
    chg_n   = chg_q && !clk_en;
    err_n   = err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_n = '0;
        if (!lock_s)      state_n = ST_WAIT_LOCK;
        else if (pending) state_n = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        cnt_n = '0;
        if (!lock_s)       state_n = ST_WAIT_LOCK;
        else if (!pending) state_n = ST_IDLE;
        else if (accept)   state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_n = '0;
        // Waiting for a clear strobe keeps each request to a single clk_en edge.
        if (clk_en && !chg_q) begin
          mode_n  = cand;
          chg_n   = 1'b1;
          state_n = ST_WAIT_UNLOCK;
        end
      end
      ST_WAIT_UNLOCK: begin
        if (!lock_s || cnt_q == UNLOCK_LAST) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_n = ST_SETTLE;
          cnt_n   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          err_n   = 1'b1;
          state_n = ST_ISSUE;
          cnt_n   = '0;
        end
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          err_n   = 1'b0;
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_WAIT_LOCK;
        cnt_n   = '0;
      end
    endcase
  end

  // Video keeps running while a new selection is only being debounced.
  assign vid_reset          = !(lock_s && (state_q == ST_IDLE || state_q == ST_DEBOUNCE));
  assign busy               = (state_q != ST_IDLE);
  assign timing_mode        = mode_q;
  assign timing_mode_change = chg_q;
  assign lock_err           = err_q;

endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// Directed bench for vpg_mode_ctrl: stimulus pushes expected strobe modes into a
// queue; a negedge monitor checks every timing_mode_change pulse against it.
module tb_vpg_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic [2:0] mode_sel;
  logic       pll_locked;
  logic [2:0] timing_mode;
  logic       timing_mode_change;
  logic       vid_reset;
  logic       busy;
  logic       lock_err;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  vpg_mode_ctrl #(
    .INIT_MODE       (3'd0),
    .DEBOUNCE_CYCLES (8),
    .UNLOCK_TIMEOUT  (16),
    .LOCK_TIMEOUT    (64),
    .SETTLE_CYCLES   (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .clk_en             (clk_en),
    .mode_sel           (mode_sel),
    .pll_locked         (pll_locked),
    .timing_mode        (timing_mode),
    .timing_mode_change (timing_mode_change),
    .vid_reset          (vid_reset),
    .busy               (busy),
    .lock_err           (lock_err)
  );

  initial forever #5 clk = ~clk;

  // clk_en: one clock in three
  initial begin
    int ph;
    ph = 0;
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph == 2) ? 0 : ph + 1;
      clk_en = (ph == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string name, input int limit, output int lat);
    lat = 0;
    while (!timing_mode_change && lat < limit) begin
      tick(1);
      lat++;
    end
    check({name, "_strobe_seen"}, int'(timing_mode_change), 1);
  endtask

  task automatic relock_check(input string name);
    pll_locked = 1'b1;
    tick(6);
    check({name, "_vidrst_settling"}, int'(vid_reset), 1);
    tick(1);
    check({name, "_vidrst_released"}, int'(vid_reset), 0);
    check({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic pll_cycle(input string name);
    tick(5);
    pll_locked = 1'b0;
    tick(20);
    relock_check(name);
  endtask

  // Scoreboard monitor
  initial begin
    logic       prev;
    logic       moved;
    logic [2:0] hold;
    int         en_edges;
    prev = 1'b0; moved = 1'b0; hold = 3'd0; en_edges = 0;
    forever begin
      @(negedge clk);
      if (timing_mode_change && !prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_strobe: got mode %0d, no change expected", timing_mode);
        end else begin
          check("strobe_mode", int'(timing_mode), exp_q.pop_front());
        end
        hold = timing_mode;
        moved = 1'b0;
        en_edges = 0;
      end
      if (timing_mode_change) begin
        if (timing_mode != hold) moved = 1'b1;
        if (clk_en) en_edges++;
      end else if (prev) begin
        check("strobe_en_edges", en_edges, 1);
        check("strobe_mode_stable", int'(moved), 0);
      end
      prev = timing_mode_change;
    end
  end

  initial begin
    int lat;
    int k;
    logic saw_busy;

    // 1: reset with PLL already locked
    reset = 1'b1; pll_locked = 1'b1; mode_sel = 3'd0;
    tick(3);
    check("rst_vid_reset", int'(vid_reset), 1);
    check("rst_busy", int'(busy), 1);
    check("rst_strobe", int'(timing_mode_change), 0);
    check("rst_mode", int'(timing_mode), 0);
    check("rst_lock_err", int'(lock_err), 0);
    reset = 1'b0;
    tick(6);
    check("t1_vidrst_hold", int'(vid_reset), 1);
    tick(1);
    check("t1_vidrst_release", int'(vid_reset), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_mode", int'(timing_mode), 0);

    // 2: clean change 0 -> 2
    mode_sel = 3'd2; exp_q.push_back(2);
    wait_strobe("t2", 30, lat);
    check("t2_latency_ok", int'(lat >= 11 && lat <= 14), 1);
    check("t2_mode", int'(timing_mode), 2);
    check("t2_vidrst_during", int'(vid_reset), 1);
    pll_cycle("t2");

    // 3: bouncing select, settles on 3
    for (int i = 0; i < 4; i++) begin
      mode_sel = (i % 2 == 0) ? 3'd3 : 3'd2;
      tick(5);
    end
    mode_sel = 3'd3; exp_q.push_back(3);
    wait_strobe("t3", 30, lat);
    check("t3_latency_ok", int'(lat >= 11 && lat <= 14), 1);
    check("t3_mode", int'(timing_mode), 3);
    pll_cycle("t3");

    // 4: unsupported codes are ignored
    saw_busy = 1'b0;
    mode_sel = 3'd4;
    for (int i = 0; i < 20; i++) begin tick(1); if (busy) saw_busy = 1'b1; end
    mode_sel = 3'd7;
    for (int i = 0; i < 20; i++) begin tick(1); if (busy) saw_busy = 1'b1; end
    check("t4_no_busy", int'(saw_busy), 0);
    check("t4_mode_kept", int'(timing_mode), 3);
    mode_sel = 3'd3;
    tick(3);

    // 5: PLL fails to relock, retry with same mode
    mode_sel = 3'd1; exp_q.push_back(1);
    wait_strobe("t5a", 30, lat);
    exp_q.push_back(1);
    tick(5);
    pll_locked = 1'b0;
    tick(20);
    check("t5_err_not_yet", int'(lock_err), 0);
    check("t5_vidrst_unlocked", int'(vid_reset), 1);
    wait_strobe("t5b", 100, lat);
    check("t5_lock_err_set", int'(lock_err), 1);
    check("t5_retry_mode", int'(timing_mode), 1);
    relock_check("t5");
    check("t5_lock_err_clear", int'(lock_err), 0);

    // 6a: lock glitch while idle
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check("t6a_vidrst_immediate", int'(vid_reset), 1);
    tick(1);
    check("t6a_busy", int'(busy), 1);
    tick(4);
    check("t6a_vidrst_settling", int'(vid_reset), 1);
    tick(1);
    check("t6a_vidrst_release", int'(vid_reset), 0);
    check("t6a_mode_kept", int'(timing_mode), 1);

    // 6b: reset while waiting for lock
    mode_sel = 3'd5; exp_q.push_back(5);
    wait_strobe("t6b", 30, lat);
    tick(5);
    pll_locked = 1'b0;
    tick(10);
    check("t6b_busy_wait", int'(busy), 1);
    mode_sel = 3'd0;
    reset = 1'b1;
    #1;
    check("t6b_rst_mode", int'(timing_mode), 0);
    check("t6b_rst_strobe", int'(timing_mode_change), 0);
    check("t6b_rst_vidrst", int'(vid_reset), 1);
    check("t6b_rst_lock_err", int'(lock_err), 0);
    pll_locked = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    check("t6b_vidrst_hold", int'(vid_reset), 1);
    tick(1);
    check("t6b_vidrst_release", int'(vid_reset), 0);
    check("t6b_mode_init", int'(timing_mode), 0);

    // 6c: select changes during SETTLE, applied only after IDLE
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(3);
    check("t6c_busy_settle", int'(busy), 1);
    mode_sel = 3'd6; exp_q.push_back(6);
    k = 0;
    while (busy && k < 20) begin tick(1); k++; end
    check("t6c_idle_reached", int'(busy), 0);
    check("t6c_mode_still_old", int'(timing_mode), 0);
    wait_strobe("t6c", 30, lat);
    check("t6c_latency_ok", int'(lat >= 10 && lat <= 12), 1);
    check("t6c_mode", int'(timing_mode), 6);
    pll_cycle("t6c");

    tick(5);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
